// File: rtl/is_uart_sync_filt_pkg.sv
// -----------------------------------------------------------------------------
// is_uart_pkg
//   Shared constants and helpers for the UART RX input conditioner.
//   GLITCH_CNT_W  width of each per-channel rejected-glitch counter
//   IDLE_LVL_DEF  default UART line idle level (mark = 1)
//   filt_cnt_w()  width of the per-channel filter counter for a given FILT_LEN
// -----------------------------------------------------------------------------
package is_uart_pkg;

   localparam int unsigned GLITCH_CNT_W = 8;
   localparam logic        IDLE_LVL_DEF = 1'b1;

   function automatic int unsigned filt_cnt_w(input int unsigned filt_len);
      return $clog2(filt_len + 1);
   endfunction

endpackage : is_uart_pkg

// File: rtl/is_uart_sync_filt_ch.sv
// -----------------------------------------------------------------------------
// is_uart_sync_filt_ch
//   One UART RX input channel: SYNC_STAGES-deep metastability synchroniser,
//   consecutive-sample glitch filter and registered fall/rise edge pulses.
//   Optional feature macro: IS_UART_SYNC_GLITCH_CNT_EN (saturating counter of
//   rejected glitches with synchronous clear).
// Ports
//   clk_i         clock
//   rstn_i        asynchronous active-low reset
//   rxd_i         raw asynchronous RX line
//   rxd_o         synchronised, filtered RX line
//   fall_o        1-cycle pulse when rxd_o goes 1->0
//   rise_o        1-cycle pulse when rxd_o goes 0->1
//   glitch_clr_i  [macro only] clear the glitch counter (wins over increment)
//   glitch_cnt_o  [macro only] saturating rejected-glitch count
// -----------------------------------------------------------------------------
module is_uart_sync_filt_ch
   import is_uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4,
   parameter logic        IDLE_LVL    = IDLE_LVL_DEF
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    rxd_i,
   output logic                    rxd_o,
   output logic                    fall_o,
   output logic                    rise_o
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
   ,
   input  logic                    glitch_clr_i,
   output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
`endif
);

   localparam int unsigned      CNT_W    = filt_cnt_w(FILT_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("is_uart_sync_filt_ch: SYNC_STAGES must be >= 2");
   end
   if (FILT_LEN < 1) begin : g_bad_filt_len
      $error("is_uart_sync_filt_ch: FILT_LEN must be >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rxd_q, rxd_d;
   logic                   fall_q, fall_d;
   logic                   rise_q, rise_d;
   logic                   s;

   // Plain shift chain: no logic between stages.
   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rxd_i};
      rxd_d  = rxd_q;
      cnt_d  = '0;
      fall_d = 1'b0;
      rise_d = 1'b0;
      if (s != rxd_q) begin
         if (cnt_q == CNT_LAST) begin
            // FILT_LEN consecutive differing samples: accept the new level and
            // flag the edge on the same clock that moves rxd_o.
            rxd_d  = s;
            fall_d = ~s;
            rise_d = s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q <= {SYNC_STAGES{IDLE_LVL}};
         cnt_q  <= '0;
         rxd_q  <= IDLE_LVL;
         fall_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         rxd_q  <= rxd_d;
         fall_q <= fall_d;
         rise_q <= rise_d;
      end
   end

   assign rxd_o  = rxd_q;
   assign fall_o = fall_q;
   assign rise_o = rise_q;

`ifdef IS_UART_SYNC_GLITCH_CNT_EN
   logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;
   logic                    glitch_rej;

   // A glitch is rejected when the line returns to rxd_o before the filter
   // counter has run out.
   assign glitch_rej = (s == rxd_q) && (cnt_q != '0);

   always_comb begin
      glitch_d = glitch_q;
      if (glitch_clr_i) begin
         glitch_d = '0;
      end else if (glitch_rej && (glitch_q != '1)) begin
         glitch_d = glitch_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         glitch_q <= '0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_cnt_o = glitch_q;
`endif

endmodule : is_uart_sync_filt_ch

// File: rtl/is_uart_sync_filt.sv
// -----------------------------------------------------------------------------
// is_uart_sync_filt
//   Multi-channel UART RX input conditioner placed between the pads and the RX
//   FSMs. Each channel is synchronised, glitch-filtered and edge-detected
//   independently; fall_o marks a start-bit candidate.
//   SYNC_STAGES=2, FILT_LEN=1 reproduces the older 3-cycle plain synchroniser.
//   Optional feature macro: IS_UART_SYNC_GLITCH_CNT_EN.
// Ports
//   clk_i         clock
//   rstn_i        asynchronous active-low reset
//   uart_rxd_i    [N_CH] raw asynchronous RX lines
//   rxd_o         [N_CH] synchronised, filtered RX lines
//   fall_o        [N_CH] 1-cycle pulse on rxd_o 1->0
//   rise_o        [N_CH] 1-cycle pulse on rxd_o 0->1
//   glitch_clr_i  [macro only] clear all glitch counters
//   glitch_cnt_o  [macro only] [N_CH*8] per-channel counters, ch0 in [7:0]
// -----------------------------------------------------------------------------
module is_uart_sync_filt
   import is_uart_pkg::*;
#(
   parameter int unsigned N_CH        = 1,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4,
   parameter logic        IDLE_LVL    = IDLE_LVL_DEF
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [N_CH-1:0]              uart_rxd_i,
   output logic [N_CH-1:0]              rxd_o,
   output logic [N_CH-1:0]              fall_o,
   output logic [N_CH-1:0]              rise_o
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
   ,
   input  logic                         glitch_clr_i,
   output logic [N_CH*GLITCH_CNT_W-1:0] glitch_cnt_o
`endif
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      is_uart_sync_filt_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_LEN    (FILT_LEN),
         .IDLE_LVL    (IDLE_LVL)
      ) u_ch (
         .clk_i        (clk_i),
         .rstn_i       (rstn_i),
         .rxd_i        (uart_rxd_i[i]),
         .rxd_o        (rxd_o[i]),
         .fall_o       (fall_o[i]),
         .rise_o       (rise_o[i])
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
         ,
         .glitch_clr_i (glitch_clr_i),
         .glitch_cnt_o (glitch_cnt_o[i*GLITCH_CNT_W +: GLITCH_CNT_W])
`endif
      );
   end

endmodule : is_uart_sync_filt

// File: tb/tb_is_uart_sync_filt.sv
module tb_is_uart_sync_filt;
   import is_uart_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [1:0] uart_a = 2'b11;
   logic [1:0] rxd_a, fall_a, rise_a;
   logic [0:0] uart_b = 1'b1;
   logic [0:0] rxd_b, fall_b, rise_b;
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
   logic        glitch_clr = 1'b0;
   logic [15:0] gcnt_a;
   logic [7:0]  gcnt_b;
`endif

   always #5 clk = ~clk;

   // Main DUT: two channels, default synchroniser/filter depth.
   is_uart_sync_filt #(
      .N_CH        (2),
      .SYNC_STAGES (2),
      .FILT_LEN    (4),
      .IDLE_LVL    (1'b1)
   ) dut_a (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .uart_rxd_i   (uart_a),
      .rxd_o        (rxd_a),
      .fall_o       (fall_a),
      .rise_o       (rise_a)
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
      ,
      .glitch_clr_i (glitch_clr),
      .glitch_cnt_o (gcnt_a)
`endif
   );

   // Legacy configuration: plain 3-cycle synchroniser.
   is_uart_sync_filt #(
      .N_CH        (1),
      .SYNC_STAGES (2),
      .FILT_LEN    (1),
      .IDLE_LVL    (1'b1)
   ) dut_b (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .uart_rxd_i   (uart_b),
      .rxd_o        (rxd_b),
      .fall_o       (fall_b),
      .rise_o       (rise_b)
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
      ,
      .glitch_clr_i (glitch_clr),
      .glitch_cnt_o (gcnt_b)
`endif
   );

   typedef struct packed {
      logic [1:0] rxd;
      logic [1:0] fall;
      logic [1:0] rise;
   } exp_a_t;

   exp_a_t sb_a[$];
   logic   sb_b[$];
   int     vec_cnt = 0;
   int     err_cnt = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_a(input logic [1:0] rxd, input logic [1:0] fall, input logic [1:0] rise);
      exp_a_t e;
      e.rxd  = rxd;
      e.fall = fall;
      e.rise = rise;
      sb_a.push_back(e);
   endtask

   task automatic push_idle_a(input int n);
      for (int k = 0; k < n; k++) push_a(2'b11, 2'b00, 2'b00);
   endtask

   // One clock, then compare DUT A against the next scoreboard entry.
   task automatic tick_a(input string tag);
      exp_a_t e;
      @(posedge clk);
      #1;
      if (sb_a.size() == 0) begin
         vec_cnt++;
         err_cnt++;
         $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      end else begin
         e = sb_a.pop_front();
         check({tag, "_rxd"},  {14'd0, rxd_a},  {14'd0, e.rxd});
         check({tag, "_fall"}, {14'd0, fall_a}, {14'd0, e.fall});
         check({tag, "_rise"}, {14'd0, rise_a}, {14'd0, e.rise});
      end
   endtask

   // Drive uart_a to lvl for `width` clocks, return to idle, total ticks checked.
   task automatic pulse_a(input logic [1:0] lvl, input int width, input int total, input string tag);
      uart_a = lvl;
      for (int k = 1; k <= total; k++) begin
         tick_a(tag);
         if (k == width) uart_a = 2'b11;
      end
   endtask

   // Expectations for a ch0 low pulse that is long enough to pass: fall on
   // edge 6 (2 sync + 4 filter), rise FILT_LEN edges later.
   task automatic push_pass_pulse_ch0(input int total, input int fall_at, input int rise_at);
      for (int k = 1; k <= total; k++) begin
         push_a({1'b1, ((k >= fall_at) && (k < rise_at)) ? 1'b0 : 1'b1},
                {1'b0, (k == fall_at)}, {1'b0, (k == rise_at)});
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic prev_b;
      logic e_b;
      logic nb;

      // ---- 1: reset held, inputs toggling ----
      rstn = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         check("rst_rxd_a",  {14'd0, rxd_a},  16'h0003);
         check("rst_fall_a", {14'd0, fall_a}, 16'h0000);
         check("rst_rise_a", {14'd0, rise_a}, 16'h0000);
         check("rst_rxd_b",  {15'd0, rxd_b},  16'h0001);
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
         check("rst_gcnt_a", gcnt_a, 16'h0000);
`endif
         uart_a = 2'($urandom);
         uart_b = 1'($urandom);
      end
      uart_a = 2'b11;
      uart_b = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      push_idle_a(6);
      for (int k = 0; k < 6; k++) tick_a("post_rst");

      // ---- 2: ch0 step 1->0 lands 6 edges later, ch1 untouched ----
      uart_a = 2'b10;
      for (int k = 1; k <= 8; k++)
         push_a({1'b1, (k >= 6) ? 1'b0 : 1'b1}, {1'b0, (k == 6)}, 2'b00);
      for (int k = 1; k <= 8; k++) tick_a("step_fall");
      uart_a = 2'b11;
      for (int k = 1; k <= 8; k++)
         push_a({1'b1, (k >= 6) ? 1'b1 : 1'b0}, 2'b00, {1'b0, (k == 6)});
      for (int k = 1; k <= 8; k++) tick_a("step_rise");

      // ---- 3: 3-cycle glitch rejected, 4-cycle pulse passes ----
      push_idle_a(10);
      pulse_a(2'b10, 3, 10, "glitch3");
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
      check("gcnt_after_glitch3", gcnt_a, 16'h0001);
`endif
      push_pass_pulse_ch0(12, 6, 10);
      pulse_a(2'b10, 4, 12, "pulse4");
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
      check("gcnt_after_pulse4", gcnt_a, 16'h0001);
`endif
      // ch1 4-cycle pulse passes while ch0 3-cycle glitch on the same cycles is rejected
      uart_a = 2'b00;
      for (int k = 1; k <= 12; k++)
         push_a({((k >= 6) && (k < 10)) ? 1'b0 : 1'b1, 1'b1}, {(k == 6), 1'b0}, {(k == 10), 1'b0});
      for (int k = 1; k <= 12; k++) begin
         tick_a("indep");
         if (k == 3) uart_a = 2'b01;
         if (k == 4) uart_a = 2'b11;
      end
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
      check("gcnt_indep", gcnt_a, 16'h0002);
`endif

      // ---- 4: legacy config, rxd_b = input delayed 3 cycles ----
      prev_b = 1'b1;
      for (int k = 0; k < 3; k++) sb_b.push_back(1'b1);
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         e_b = sb_b.pop_front();
         check("legacy_rxd",  {15'd0, rxd_b},  {15'd0, e_b});
         check("legacy_fall", {15'd0, fall_b}, {15'd0, prev_b & ~e_b});
         check("legacy_rise", {15'd0, rise_b}, {15'd0, ~prev_b & e_b});
         prev_b = e_b;
         nb = (k < 196) ? 1'($urandom) : 1'b1;
         uart_b = nb;
         sb_b.push_back(nb);
      end

      // ---- 6: reset while filter counter is part-way ----
      uart_a = 2'b10;
      push_idle_a(4);
      for (int k = 0; k < 4; k++) tick_a("pre_rst_mid");
      #2;
      rstn = 1'b0;
      uart_a = 2'b11;
      #1;
      check("rst_mid_rxd",  {14'd0, rxd_a},  16'h0003);
      check("rst_mid_fall", {14'd0, fall_a}, 16'h0000);
      check("rst_mid_rise", {14'd0, rise_a}, 16'h0000);
`ifdef IS_UART_SYNC_GLITCH_CNT_EN
      check("rst_mid_gcnt", gcnt_a, 16'h0000);
`endif
      @(negedge clk);
      rstn = 1'b1;
      push_idle_a(3);
      for (int k = 0; k < 3; k++) tick_a("post_rst_mid");
      push_idle_a(10);
      pulse_a(2'b10, 3, 10, "rst_glitch3");
      push_pass_pulse_ch0(12, 6, 10);
      pulse_a(2'b10, 4, 12, "rst_pulse4");

`ifdef IS_UART_SYNC_GLITCH_CNT_EN
      check("gcnt_post_rst", gcnt_a, 16'h0001);
      // ---- 5: saturation and clear-wins ----
      for (int k = 0; k < 300; k++) begin
         uart_a = 2'b10;
         @(posedge clk);
         #1;
         uart_a = 2'b11;
         @(posedge clk);
         #1;
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
      end
      check("sat_gcnt", gcnt_a, 16'h00FF);
      check("sat_rxd", {14'd0, rxd_a}, 16'h0003);
      uart_a = 2'b10;
      @(posedge clk);
      #1;
      uart_a = 2'b11;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
      end
      glitch_clr = 1'b1;
      @(posedge clk);
      #1;
      glitch_clr = 1'b0;
      check("clr_wins", gcnt_a, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
      end
      check("clr_hold", gcnt_a, 16'h0000);
`endif

      check("sb_a_drained", 16'(sb_a.size()), 16'h0000);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule : tb_is_uart_sync_filt
